multiplicador_shift_add: RTL and testbench

Sequential unsigned multiplier using the shift-add algorithm. It multiplies an N-bit multiplicand by an N-bit multiplier, one multiplier bit per clock, and returns a 2N-bit product. A start/idle/done handshake lets a controlling FSM or bus-side wrapper launch one multiplication at a time.

---
 rtl/multiplicador_pkg.sv | 18 +
 rtl/multiplicador_ctrl.sv | 76 +++++++
 rtl/multiplicador_shift_add.sv | 92 +++++++++
 tb/tb_multiplicador_shift_add.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the shift-add multiplier.
// The optional early-termination path is enabled by MULTIPLICADOR_EARLY_DONE_EN.
package multiplicador_pkg;

  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must be able to hold N itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiplicador_ctrl.sv
// Control FSM and step counter for the shift-add multiplier.
// With MULTIPLICADOR_EARLY_DONE_EN, the datapath may cut CALC short via early_i.
module multiplicador_ctrl
  import multiplicador_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MULTIPLICADOR_EARLY_DONE_EN
  input  logic                early_i,
  output logic [cnt_w(N)-1:0] cnt_o,
`endif
  input  logic                st_i,
  output logic                load_o,
  output logic                step_o,
  output logic                last_o,
  output logic                idle_o,
  output logic                done_o
);

  localparam int CW = cnt_w(N);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    step_o  = 1'b0;
    last_o  = 1'b0;
    idle_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_o = 1'b1;
        if (st_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
`ifdef MULTIPLICADOR_EARLY_DONE_EN
        last_o = (cnt_q == CW'(N - 1)) || early_i;
`else
        last_o = (cnt_q == CW'(N - 1));
`endif
        if (last_o) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MULTIPLICADOR_EARLY_DONE_EN
  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/multiplicador_shift_add.sv
// Sequential unsigned N x N shift-add multiplier, one multiplier bit per clock.
// Define MULTIPLICADOR_EARLY_DONE_EN to finish as soon as the remaining multiplier bits are zero.
module multiplicador_shift_add
  import multiplicador_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           St,
  input  logic [N-1:0]   Multiplicando,
  input  logic [N-1:0]   Multiplicador,
  output logic           Idle,
  output logic           Done,
  output logic [2*N-1:0] Produto
);

  logic [2*N:0]   acc_q, acc_d, acc_sh;
  logic [N-1:0]   m_q, m_d;
  logic [2*N-1:0] produto_q, produto_d, res;
  logic [N:0]     sum;
  logic           load, step, last;

`ifdef MULTIPLICADOR_EARLY_DONE_EN
  logic                early;
  logic [cnt_w(N)-1:0] cnt;
  logic [2*N:0]        acc_res;
`endif

  multiplicador_ctrl #(.N(N)) u_ctrl (
    .clk     (Clk),
    .rst     (Rst),
`ifdef MULTIPLICADOR_EARLY_DONE_EN
    .early_i (early),
    .cnt_o   (cnt),
`endif
    .st_i    (St),
    .load_o  (load),
    .step_o  (step),
    .last_o  (last),
    .idle_o  (Idle),
    .done_o  (Done)
  );

  // ACC[2N] is zero between steps, so the upper half plus M fits in N+1 bits.
  always_comb begin
    sum    = acc_q[2*N:N] + (acc_q[0] ? {1'b0, m_q} : '0);
    acc_sh = {sum, acc_q[N-1:0]} >> 1;
  end

`ifdef MULTIPLICADOR_EARLY_DONE_EN
  // Unconsumed multiplier bits after this step sit in ACC[N-1-cnt:1].
  always_comb begin
    early = 1'b1;
    for (int i = 1; i < N; i++) begin
      if ((i + int'(cnt)) <= (N - 1) && acc_q[i]) early = 1'b0;
    end
    acc_res = acc_sh >> (N - 1 - int'(cnt));
    res     = acc_res[2*N-1:0];
  end
`else
  assign res = acc_sh[2*N-1:0];
`endif

  always_comb begin
    acc_d     = acc_q;
    m_d       = m_q;
    produto_d = produto_q;
    if (load) begin
      acc_d = {{(N+1){1'b0}}, Multiplicador};
      m_d   = Multiplicando;
    end else if (step) begin
      acc_d = acc_sh;
      if (last) produto_d = res;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q     <= '0;
      m_q       <= '0;
      produto_q <= '0;
    end else begin
      acc_q     <= acc_d;
      m_q       <= m_d;
      produto_q <= produto_d;
    end
  end

  assign Produto = produto_q;

endmodule

// File: tb/tb_multiplicador_shift_add.sv
// Self-checking bench for multiplicador_shift_add: directed cases plus random operands
// against an arithmetic reference (product = a*b, latency from the multiplier's top set bit).
module tb_multiplicador_shift_add;
  localparam int N = 4;

  logic           Clk = 1'b0;
  logic           Rst, St;
  logic [N-1:0]   A, B;
  logic           Idle, Done;
  logic [2*N-1:0] Produto;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] prev_p;

  multiplicador_shift_add #(.N(N)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .St            (St),
    .Multiplicando (A),
    .Multiplicador (B),
    .Idle          (Idle),
    .Done          (Done),
    .Produto       (Produto)
  );

  always #5 Clk = ~Clk;

  function automatic int exp_lat(input int b);
`ifdef MULTIPLICADOR_EARLY_DONE_EN
    int h = -1;
    for (int i = 0; i < N; i++) if (((b >> i) & 1) == 1) h = i;
    return (h < 0) ? 1 : h + 1;
`else
    return N;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Idle !== 1'b1 && n < 30) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", {63'd0, Idle}, 64'd1);
  endtask

  // Launch a*b with a one-cycle St pulse; optionally disturb St and operands mid-run.
  task automatic run(input int a, input int b, input bit perturb);
    int lat;
    wait_idle();
    @(negedge Clk);
    St = 1'b1; A = N'(a); B = N'(b);
    @(negedge Clk);
    St = 1'b0;
    chk("idle_drop", {63'd0, Idle}, 64'd0);
    for (lat = 1; lat <= N + 4; lat++) begin
      @(negedge Clk);
      if (perturb && lat == 2) begin St = 1'b1; A = ~A; B = ~B; end
      else if (perturb && lat == 3) St = 1'b0;
      if (Done === 1'b1) break;
      chk("produto_hold", {56'd0, Produto}, {56'd0, prev_p});
      chk("idle_busy", {63'd0, Idle}, 64'd0);
    end
    St = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat(b)));
    chk("produto", {56'd0, Produto}, 64'(a * b));
    chk("idle_at_done", {63'd0, Idle}, 64'd0);
    prev_p = 8'(a * b);
    @(negedge Clk);
    chk("idle_after", {63'd0, Idle}, 64'd1);
    chk("done_pulse", {63'd0, Done}, 64'd0);
    if (perturb) begin
      for (int i = 0; i < N + 3; i++) begin
        @(negedge Clk);
        chk("no_extra_done", {63'd0, Done}, 64'd0);
      end
      chk("produto_kept", {56'd0, Produto}, {56'd0, prev_p});
    end
  endtask

  initial begin
    int t1, t2, cyc;
    Rst = 1'b1; St = 1'b0; A = '0; B = '0; prev_p = '0;
    repeat (2) @(negedge Clk);
    chk("rst_idle", {63'd0, Idle}, 64'd1);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_produto", {56'd0, Produto}, 64'd0);
    Rst = 1'b0;

    // Back-to-back directed cases
    run(2, 0, 1'b0);
    run(2, 10, 1'b0);
    run(15, 15, 1'b0);
    run(15, 15, 1'b1);

    // Reset during CALC step 2
    wait_idle();
    @(negedge Clk); St = 1'b1; A = 4'd15; B = 4'd15;
    @(negedge Clk); St = 1'b0;
    @(negedge Clk);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0;
    chk("midrst_idle", {63'd0, Idle}, 64'd1);
    chk("midrst_done", {63'd0, Done}, 64'd0);
    chk("midrst_produto", {56'd0, Produto}, 64'd0);
    prev_p = '0;
    run(3, 5, 1'b0);

    // Edge operands and random operands
    run(0, 15, 1'b0);
    run(15, 1, 1'b0);
    run(1, 8, 1'b0);
    for (int i = 0; i < 24; i++) run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

    // St held high: a new run starts on every return to IDLE
    wait_idle();
    @(negedge Clk); St = 1'b1; A = 4'd3; B = 4'd3;
    t1 = -1; t2 = -1;
    for (cyc = 0; cyc < 40 && t2 < 0; cyc++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
    end
    St = 1'b0;
    chk("hold_period", 64'(t2 - t1), 64'(exp_lat(3) + 2));
    chk("hold_produto", {56'd0, Produto}, 64'd9);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
